// File: rtl/regfile_sb.sv
// Register file with per-register scoreboard busy bits and a sequential bulk-clear engine.
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle write data and busy state to the read ports.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [AW-1:0]   i_Rnum1,
  input  logic [AW-1:0]   i_Rnum2,
  output logic [XLEN-1:0] o_Rd1,
  output logic [XLEN-1:0] o_Rd2,
  output logic            o_Busy1,
  output logic            o_Busy2,
  input  logic            i_Wen,
  input  logic [AW-1:0]   i_Wnum,
  input  logic [XLEN-1:0] i_Wd,
  input  logic            i_Alloc_en,
  input  logic [AW-1:0]   i_Alloc_num,
  input  logic            i_Clr,
  output logic            o_Clr_busy,
  output logic            o_Rdy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   cnt_q;
  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q;

  logic rdy;
  logic clr_act;
  logic wr_acc;
  logic alloc_acc;

  // Register 0 is never written or allocated, so it stays at its reset value forever.
  assign wr_acc    = i_Wen      && rdy && (i_Wnum      != '0);
  assign alloc_acc = i_Alloc_en && rdy && (i_Alloc_num != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_Clr) state_d = S_CLEAR;
      S_CLEAR: if (cnt_q == LAST_IDX) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clr_act = (state_q == S_CLEAR);
    rdy     = !clr_act;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE && i_Clr) begin
      cnt_q <= ONE_IDX;
    end else if (clr_act) begin
      cnt_q <= cnt_q + ONE_IDX;
    end
  end

  // Writes and the clear walker are mutually exclusive because writes need rdy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      if (wr_acc)  mem_q[i_Wnum] <= i_Wd;
      if (clr_act) mem_q[cnt_q]  <= '0;
    end
  end

  // Alloc is applied after the write clear so the newer producer wins on a collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
    end else begin
      if (wr_acc)    busy_q[i_Wnum]      <= 1'b0;
      if (alloc_acc) busy_q[i_Alloc_num] <= 1'b1;
      if (clr_act)   busy_q[cnt_q]       <= 1'b0;
    end
  end

  always_comb begin
    o_Rd1   = mem_q[i_Rnum1];
    o_Busy1 = busy_q[i_Rnum1];
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_acc && (i_Wnum == i_Rnum1)) begin
      o_Rd1   = i_Wd;
      o_Busy1 = alloc_acc && (i_Alloc_num == i_Rnum1);
    end
`endif
    if (i_Rnum1 == '0) begin
      o_Rd1   = '0;
      o_Busy1 = 1'b0;
    end
  end

  always_comb begin
    o_Rd2   = mem_q[i_Rnum2];
    o_Busy2 = busy_q[i_Rnum2];
`ifdef REGFILE_SB_BYPASS_EN
    if (wr_acc && (i_Wnum == i_Rnum2)) begin
      o_Rd2   = i_Wd;
      o_Busy2 = alloc_acc && (i_Alloc_num == i_Rnum2);
    end
`endif
    if (i_Rnum2 == '0) begin
      o_Rd2   = '0;
      o_Busy2 = 1'b0;
    end
  end

  assign o_Clr_busy = clr_act;
  assign o_Rdy      = rdy;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default 32x32 instance plus a 64-bit, 16-entry instance.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  a_rnum1 = '0, a_rnum2 = '0, a_wnum = '0, a_anum = '0;
  logic [31:0] a_rd1, a_rd2, a_wd = '0;
  logic        a_b1, a_b2, a_wen = 1'b0, a_aen = 1'b0, a_clr = 1'b0, a_cb, a_rdy;

  logic [3:0]  b_rnum1 = '0, b_rnum2 = '0, b_wnum = '0, b_anum = '0;
  logic [63:0] b_rd1, b_rd2, b_wd = '0;
  logic        b_b1, b_b2, b_wen = 1'b0, b_aen = 1'b0, b_clr = 1'b0, b_cb, b_rdy;

  regfile_sb #(.XLEN(32), .NREG(32)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_Rnum1(a_rnum1), .i_Rnum2(a_rnum2), .o_Rd1(a_rd1), .o_Rd2(a_rd2),
    .o_Busy1(a_b1), .o_Busy2(a_b2),
    .i_Wen(a_wen), .i_Wnum(a_wnum), .i_Wd(a_wd),
    .i_Alloc_en(a_aen), .i_Alloc_num(a_anum),
    .i_Clr(a_clr), .o_Clr_busy(a_cb), .o_Rdy(a_rdy)
  );

  regfile_sb #(.XLEN(64), .NREG(16)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_Rnum1(b_rnum1), .i_Rnum2(b_rnum2), .o_Rd1(b_rd1), .o_Rd2(b_rd2),
    .o_Busy1(b_b1), .o_Busy2(b_b2),
    .i_Wen(b_wen), .i_Wnum(b_wnum), .i_Wd(b_wd),
    .i_Alloc_en(b_aen), .i_Alloc_num(b_anum),
    .i_Clr(b_clr), .o_Clr_busy(b_cb), .o_Rdy(b_rdy)
  );

  typedef struct {
    int          dut;
    string       nm;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        b1, b2, cb, rdy;
  } exp_t;

  exp_t q[$];
  logic smp = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic expect_out(input int dut, input string nm, input logic [63:0] rd1,
                            input logic [63:0] rd2, input logic b1, input logic b2,
                            input logic cb, input logic rdy);
    exp_t e;
    e.dut = dut; e.nm = nm; e.rd1 = rd1; e.rd2 = rd2;
    e.b1 = b1; e.b2 = b2; e.cb = cb; e.rdy = rdy;
    q.push_back(e);
    smp = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    smp = 1'b0;
    a_wen = 1'b0; a_aen = 1'b0; a_clr = 1'b0;
    b_wen = 1'b0; b_aen = 1'b0; b_clr = 1'b0;
  endtask

  task automatic wr_a(input logic [4:0] n, input logic [31:0] d);
    a_wen = 1'b1; a_wnum = n; a_wd = d;
  endtask

  task automatic al_a(input logic [4:0] n);
    a_aen = 1'b1; a_anum = n;
  endtask

  // Monitor: pops one expectation whenever the stimulus flags a sample cycle.
  always @(negedge clk) begin
    if (smp) begin
      exp_t e;
      logic [63:0] rd1, rd2;
      logic b1, b2, cb, rdy;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: sample requested with no expectation queued");
      end else begin
        e = q.pop_front();
        if (e.dut == 0) begin
          rd1 = {32'b0, a_rd1}; rd2 = {32'b0, a_rd2};
          b1 = a_b1; b2 = a_b2; cb = a_cb; rdy = a_rdy;
        end else begin
          rd1 = b_rd1; rd2 = b_rd2;
          b1 = b_b1; b2 = b_b2; cb = b_cb; rdy = b_rdy;
        end
        if (rd1 !== e.rd1 || rd2 !== e.rd2 || b1 !== e.b1 || b2 !== e.b2 ||
            cb !== e.cb || rdy !== e.rdy) begin
          bad++;
          $display("FAIL %s: got rd1=%h rd2=%h b1=%b b2=%b cb=%b rdy=%b want rd1=%h rd2=%h b1=%b b2=%b cb=%b rdy=%b",
                   e.nm, rd1, rd2, b1, b2, cb, rdy, e.rd1, e.rd2, e.b1, e.b2, e.cb, e.rdy);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while i_rst_n is held low
    @(posedge clk); #1;
    a_rnum1 = 5'd5; a_rnum2 = 5'd0;
    expect_out(0, "reset_state", 0, 0, 0, 0, 0, 1);
    tick();
    rst_n = 1'b1;

    wr_a(5'd5, 32'hDEADBEEF);
    expect_out(0, "wr_x5_same", BYP ? 64'hDEADBEEF : 64'h0, 0, 0, 0, 0, 1);
    tick();
    wr_a(5'd0, 32'h1234);
    expect_out(0, "rd_x5", 64'hDEADBEEF, 0, 0, 0, 0, 1);
    tick();
    expect_out(0, "rd_x0_after_wr", 64'hDEADBEEF, 0, 0, 0, 0, 1);
    tick();

    a_rnum1 = 5'd7;
    al_a(5'd7);
    expect_out(0, "alloc_x7_same", 0, 0, 0, 0, 0, 1);
    tick();
    expect_out(0, "busy_x7", 0, 0, 1, 0, 0, 1);
    tick();
    wr_a(5'd7, 32'h55);
    expect_out(0, "wr_x7_same", BYP ? 64'h55 : 64'h0, 0, BYP ? 1'b0 : 1'b1, 0, 0, 1);
    tick();
    expect_out(0, "busy_x7_cleared", 64'h55, 0, 0, 0, 0, 1);
    tick();

    a_rnum2 = 5'd9;
    wr_a(5'd9, 32'h99); al_a(5'd9);
    expect_out(0, "alloc_wr_x9_same", 64'h55, BYP ? 64'h99 : 64'h0, 0, BYP, 0, 1);
    tick();
    expect_out(0, "alloc_wins_x9", 64'h55, 64'h99, 0, 1, 0, 1);
    tick();

    wr_a(5'd3, 32'hA);
    tick();
    a_rnum1 = 5'd3;
    wr_a(5'd3, 32'hB);
    expect_out(0, "bypass_x3", BYP ? 64'hB : 64'hA, 64'h99, 0, 1, 0, 1);
    tick();
    expect_out(0, "rd_x3", 64'hB, 64'h99, 0, 1, 0, 1);
    tick();

    a_rnum1 = 5'd0;
    al_a(5'd0);
    tick();
    expect_out(0, "alloc_x0_ignored", 0, 64'h99, 0, 1, 0, 1);
    tick();

    // Fill every register, then allocate two of them
    for (int i = 1; i < 32; i++) begin
      wr_a(5'(i), 32'h100 + 32'(i));
      tick();
    end
    al_a(5'd4); tick();
    al_a(5'd9); tick();

    // Clear request with a same-cycle alloc that must still land
    a_rnum1 = 5'd4; a_rnum2 = 5'd31;
    a_clr = 1'b1; al_a(5'd20);
    expect_out(0, "pre_clear", 64'h104, 64'h11F, 1, 0, 0, 1);
    tick();

    for (int k = 0; k < 32; k++) begin
      a_rnum2 = 5'(k);
      if (k < 31) begin
        a_rnum1 = 5'(k + 1);
        if (k == 5) begin
          wr_a(5'd2, 32'hBAD); al_a(5'd2);
        end
        if (k == 6) a_clr = 1'b1;
        expect_out(0, $sformatf("clear_k%0d", k), 64'h100 + 64'(k + 1), 0,
                   (k + 1 == 4) || (k + 1 == 9) || (k + 1 == 20), 0, 1, 0);
      end else begin
        a_rnum1 = 5'd31;
        expect_out(0, "clear_done", 0, 0, 0, 0, 0, 1);
      end
      tick();
    end

    for (int i = 0; i < 32; i++) begin
      a_rnum1 = 5'(i); a_rnum2 = 5'(31 - i);
      expect_out(0, $sformatf("post_clear_x%0d", i), 0, 0, 0, 0, 0, 1);
      tick();
    end

    // Reset in the middle of a clear
    for (int i = 1; i < 32; i++) begin
      wr_a(5'(i), 32'h200 + 32'(i));
      tick();
    end
    a_clr = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) tick();
    a_rnum1 = 5'd20; a_rnum2 = 5'd31;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    expect_out(0, "mid_clear_reset", 0, 0, 0, 0, 0, 1);
    tick();
    a_rnum1 = 5'd6;
    wr_a(5'd6, 32'h66);
    expect_out(0, "wr_after_reset_same", BYP ? 64'h66 : 64'h0, 0, 0, 0, 0, 1);
    tick();
    expect_out(0, "wr_after_reset", 64'h66, 0, 0, 0, 0, 1);
    tick();

    // Wide, 16-entry instance
    b_rnum1 = 4'd15; b_rnum2 = 4'd0;
    b_wen = 1'b1; b_wnum = 4'd15; b_wd = 64'hFFFF_FFFF_0000_0001;
    tick();
    expect_out(1, "w64_rd_x15", 64'hFFFF_FFFF_0000_0001, 0, 0, 0, 0, 1);
    b_clr = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      b_rnum2 = 4'(k);
      if (k < 15)
        expect_out(1, $sformatf("w64_clear_k%0d", k), 64'hFFFF_FFFF_0000_0001, 0, 0, 0, 1, 0);
      else
        expect_out(1, "w64_clear_done", 0, 0, 0, 0, 0, 1);
      tick();
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d expectations never checked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
